// File: rtl/lc3b_types.sv
// Shared LC-3b front-end types: machine word, fetch FSM state, queue entry.
// Latency: n/a (types only).
// Backpressure: n/a.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch stage bus: instruction-cache request/response, redirect, decode queue.
// Latency: n/a (wiring only).
// Backpressure: decode throttles through iq_deq; the cache stalls by delaying icache_resp.
// Ports (master = fetch_queue side):
//   icache_read/icache_address out, icache_resp/icache_rdata in,
//   redirect/redirect_pc in, iq_deq in, iq_valid/iq_instr/iq_pc/iq_count out.
interface fetch_queue_if #(
  parameter int DEPTH = 8
);
  import lc3b_types::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          icache_read;
  lc3b_word      icache_address;
  logic          icache_resp;
  lc3b_word      icache_rdata;
  logic          redirect;
  lc3b_word      redirect_pc;
  logic          iq_deq;
  logic          iq_valid;
  lc3b_word      iq_instr;
  lc3b_word      iq_pc;
  logic [CW-1:0] iq_count;

  modport master (
    output icache_read, icache_address,
    input  icache_resp, icache_rdata,
    input  redirect, redirect_pc,
    input  iq_deq,
    output iq_valid, iq_instr, iq_pc, iq_count
  );

  modport slave (
    input  icache_read, icache_address,
    output icache_resp, icache_rdata,
    output redirect, redirect_pc,
    output iq_deq,
    input  iq_valid, iq_instr, iq_pc, iq_count
  );

endinterface

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO of fetch entries with synchronous flush.
// Latency: a push at edge N is visible at the head after edge N (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
// Ports: clk, rst_n; push/wdata, pop, flush in; rdata (head), full, empty, count out.
module fetch_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) tail_d = tail_q + AW'(1);
      if (pop_ok)  head_d = head_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is only meaningful while count != 0.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[tail_q] <= wdata;
  end

  assign rdata = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one cache read at a time, queues results.
// Latency: response at edge N is at the queue head after edge N; next request rises one cycle later.
// Backpressure: no request is issued while the queue is full; redirect flushes and drops stale data.
// Ports: clk, rst_n; bus (fetch_queue_if.master) carrying the cache, redirect and decode signals.
module fetch_queue
  import lc3b_types::*;
#(
  parameter int       DEPTH    = 8,
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_queue_if.master    bus
);

  fetch_state_t state_q, state_d;
  lc3b_word     pc_q, pc_d;
  lc3b_word     addr_q, addr_d;
  logic         req_q, req_d;

  logic         push;
  logic         pop;
  logic         start;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_wdata;
  fetch_entry_t fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // A redirect with the old request still pending must wait it out;
      // if the response lands in the redirect cycle it is simply dropped.
      FETCH:   if (bus.redirect && req_q && !bus.icache_resp) state_d = DISCARD;
      DISCARD: if (bus.icache_resp) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    push  = 1'b0;
    start = 1'b0;
    pop   = bus.iq_deq && !bus.redirect;
    unique case (state_q)
      FETCH: begin
        push  = req_q && bus.icache_resp && !bus.redirect;
        // Issue is decided from registered state only; a redirect this
        // cycle would change pc, so hold off one cycle.
        start = !req_q && !fifo_full && !bus.redirect;
      end
      DISCARD: begin
        push  = 1'b0;
        start = 1'b0;
      end
      default: begin
        push  = 1'b0;
        start = 1'b0;
      end
    endcase
  end

  // ---------------- PC and request datapath ----------------
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect)  pc_d = {bus.redirect_pc[15:1], 1'b0};
    else if (push)     pc_d = pc_q + 16'd2;

    req_d = req_q;
    if (start)                req_d = 1'b1;
    else if (bus.icache_resp) req_d = 1'b0;

    // The address is latched at issue so it stays put through DISCARD
    // even though pc already holds the redirect target.
    addr_d = start ? pc_q : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      req_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      req_q  <= req_d;
    end
  end

  // ---------------- Instruction queue ----------------
  always_comb begin
    fifo_wdata       = '0;
    fifo_wdata.pc    = addr_q;
    fifo_wdata.instr = bus.icache_rdata;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .flush (bus.redirect),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.icache_read    = req_q;
  assign bus.icache_address = addr_q;
  assign bus.iq_valid       = !fifo_empty;
  assign bus.iq_instr       = fifo_rdata.instr;
  assign bus.iq_pc          = fifo_rdata.pc;
  assign bus.iq_count       = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import lc3b_types::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_addr [$];
  logic [31:0] exp_ent  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_req(input logic [15:0] a);
    exp_addr.push_back(a);
  endtask

  // Bounded wait for icache_read; called and returns at posedge+1.
  task automatic wait_read();
    int n = 0;
    while (!bus.icache_read && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.icache_read) begin
      total++;
      bad++;
      $display("FAIL request_timeout: got icache_read=0, expected 1 within 50 cycles");
    end
  endtask

  // Answer the outstanding request after lat cycles with data.
  task automatic serve(input int lat, input logic [15:0] addr, input logic [15:0] data,
                       input bit push);
    wait_read();
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
    end
    bus.icache_resp  = 1'b1;
    bus.icache_rdata = data;
    if (push) exp_ent.push_back({addr, data});
    @(posedge clk); #1;
    bus.icache_resp  = 1'b0;
  endtask

  // Scoreboard monitor: new requests and accepted dequeues.
  initial begin
    logic prev_read;
    prev_read = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.icache_read && !prev_read) begin
          if (exp_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_request: got address %h, expected no request", bus.icache_address);
          end else begin
            check("req_addr", {16'h0, bus.icache_address}, {16'h0, exp_addr.pop_front()});
          end
        end
        if (bus.iq_deq && bus.iq_valid && !bus.redirect) begin
          if (exp_ent.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got pc/instr %h/%h, expected empty queue", bus.iq_pc, bus.iq_instr);
          end else begin
            check("pop_pc_instr", {bus.iq_pc, bus.iq_instr}, exp_ent.pop_front());
          end
        end
      end
      prev_read = bus.icache_read;
    end
  end

  initial begin
    bus.icache_resp  = 1'b0;
    bus.icache_rdata = 16'h0000;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 16'h0000;
    bus.iq_deq       = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_read",  32'(bus.icache_read), 32'd0);
    check("rst_valid", 32'(bus.iq_valid),    32'd0);
    check("rst_count", 32'(bus.iq_count),    32'd0);
    expect_req(16'h0000);
    rst_n = 1'b1;

    // Single-cycle hits
    serve(1, 16'h0000, 16'h1000, 1'b1);
    expect_req(16'h0002);
    serve(1, 16'h0002, 16'h2001, 1'b1);
    expect_req(16'h0004);
    serve(1, 16'h0004, 16'h3002, 1'b1);
    expect_req(16'h0006);
    check("count_three", 32'(bus.iq_count), 32'd3);

    // Redirect while 0x0006 is pending; two pops during the wait
    wait_read();
    bus.iq_deq = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.iq_deq      = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h4001;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    exp_ent.delete();
    check("redir_count", 32'(bus.iq_count),       32'd0);
    check("redir_valid", 32'(bus.iq_valid),       32'd0);
    check("redir_read",  32'(bus.icache_read),    32'd1);
    check("redir_addr",  32'(bus.icache_address), 32'h0006);
    expect_req(16'h4000);
    bus.icache_resp  = 1'b1;
    bus.icache_rdata = 16'hDEAD;
    @(posedge clk); #1;
    bus.icache_resp = 1'b0;
    check("stale_count", 32'(bus.iq_count), 32'd0);
    serve(1, 16'h4000, 16'h5555, 1'b1);
    expect_req(16'h4002);

    // Redirect coincident with response and dequeue; bit 0 forced low
    wait_read();
    bus.icache_resp  = 1'b1;
    bus.icache_rdata = 16'hCAFE;
    bus.iq_deq       = 1'b1;
    bus.redirect     = 1'b1;
    bus.redirect_pc  = 16'hFFFF;
    @(posedge clk); #1;
    bus.icache_resp = 1'b0;
    bus.iq_deq      = 1'b0;
    bus.redirect    = 1'b0;
    exp_ent.delete();
    expect_req(16'hFFFE);
    check("coinc_count", 32'(bus.iq_count),    32'd0);
    check("coinc_valid", 32'(bus.iq_valid),    32'd0);
    check("coinc_read",  32'(bus.icache_read), 32'd0);

    // PC wrap from 0xFFFE
    serve(1, 16'hFFFE, 16'h8FFE, 1'b1);
    expect_req(16'h0000);
    serve(1, 16'h0000, 16'h9000, 1'b1);
    expect_req(16'h0002);
    bus.iq_deq = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus.iq_deq = 1'b0;
    check("wrap_drain_count", 32'(bus.iq_count), 32'd0);

    // Reset mid-request with three entries queued
    serve(1, 16'h0002, 16'hA002, 1'b1);
    expect_req(16'h0004);
    serve(1, 16'h0004, 16'hA004, 1'b1);
    expect_req(16'h0006);
    serve(1, 16'h0006, 16'hA006, 1'b1);
    expect_req(16'h0008);
    check("pre_rst_count", 32'(bus.iq_count), 32'd3);
    wait_read();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_read",  32'(bus.icache_read), 32'd0);
    check("mid_rst_valid", 32'(bus.iq_valid),    32'd0);
    check("mid_rst_count", 32'(bus.iq_count),    32'd0);
    exp_addr.delete();
    exp_ent.delete();
    repeat (2) @(posedge clk);
    #1;
    expect_req(16'h0000);
    rst_n = 1'b1;

    // Fill to DEPTH from RESET_PC with no dequeues
    for (int i = 0; i < DEPTH; i++) begin
      serve(1, 16'(2 * i), 16'hB000 + 16'(i), 1'b1);
      if (i < DEPTH - 1) expect_req(16'(2 * (i + 1)));
    end
    check("full_count", 32'(bus.iq_count), 32'd8);
    repeat (4) begin
      @(posedge clk); #1;
      check("full_no_read", 32'(bus.icache_read), 32'd0);
    end

    // One dequeue frees one slot -> exactly one request at 0x0010
    expect_req(16'h0010);
    bus.iq_deq = 1'b1;
    @(posedge clk); #1;
    bus.iq_deq = 1'b0;
    serve(1, 16'h0010, 16'hB008, 1'b1);
    check("refull_count", 32'(bus.iq_count), 32'd8);
    repeat (3) begin
      @(posedge clk); #1;
      check("refull_no_read", 32'(bus.icache_read), 32'd0);
    end

    // Drain, then dequeue on empty is ignored
    expect_req(16'h0012);
    bus.iq_deq = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("drain_count", 32'(bus.iq_count), 32'd0);
    @(posedge clk); #1;
    bus.iq_deq = 1'b0;
    check("underflow_count", 32'(bus.iq_count), 32'd0);
    check("underflow_valid", 32'(bus.iq_valid), 32'd0);
    check("left_entries", 32'(exp_ent.size()),  32'd0);
    check("left_requests", 32'(exp_addr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of the instruction register and decode.
- Owns the fetch PC and issues word reads to the instruction cache.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO; decode pops the FIFO and loads the IR from it.
- Handles redirects from branch/trap resolution by flushing the FIFO and discarding any in-flight cache response.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two and at least 2.
- RESET_PC, 16'h0000, fetch PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- icache_read  out  1  read request; held high until icache_resp.
- icache_address  out  16  byte address of the request; stable while icache_read is high.
- icache_resp  in  1  one-cycle pulse: icache_rdata valid, request complete.
- icache_rdata  in  16  fetched instruction word.
- redirect  in  1  one-cycle pulse: flush the FIFO and restart fetch.
- redirect_pc  in  16  new fetch PC; bit 0 is ignored and forced to 0.
- iq_deq  in  1  decode consumes the head entry this cycle.
- iq_valid  out  1  FIFO not empty.
- iq_instr  out  16  head instruction word; feeds the IR data input.
- iq_pc  out  16  PC of the head instruction.
- iq_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc = RESET_PC, state = FETCH.
  - FIFO empty: head, tail and count = 0.
  - icache_read = 0, iq_valid = 0, iq_count = 0.
  - iq_instr and iq_pc read the entry at head; their value is don't-care while empty.
- Reset asserted mid-request: the request is abandoned and icache_read drops immediately.
- States:
  - FETCH: normal operation.
  - DISCARD: waiting out a stale request after a redirect.
- Request issue (FETCH):
  - A request starts when no request is outstanding and iq_count < DEPTH.
  - icache_read = 1 and icache_address = pc, held constant until icache_resp.
  - At most one request is outstanding at a time.
  - A started request is never withdrawn, except by reset.
- Response (FETCH, icache_resp = 1):
  - {pc, icache_rdata} is written at tail; tail and count increment.
  - pc <= pc + 2, wrapping from 16'hFFFE to 16'h0000.
  - The next request may be issued on the following cycle, so back-to-back single-cycle hits give one instruction per two cycles at most.
- Push latency: a response at edge N makes iq_valid = 1 after edge N, so decode sees the entry the next cycle. There is no combinational bypass.
- Dequeue:
  - iq_deq with iq_valid = 1: head increments and count decrements.
  - iq_deq with iq_valid = 0: ignored, no underflow.
- Push and dequeue in the same cycle: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Full: count == DEPTH means no new request is issued. Overflow cannot occur because issue requires count < DEPTH.
- Redirect (priority over push and dequeue in the same cycle):
  - FIFO cleared: head = tail = count = 0.
  - pc <= {redirect_pc[15:1], 1'b0}.
  - If a request is outstanding and icache_resp = 0 this cycle: go to DISCARD.
    - icache_read stays high on the old address.
    - The eventual response is dropped: no push, pc unchanged.
    - Then return to FETCH; the new request starts the cycle after.
  - If icache_resp = 1 in the redirect cycle: that data is dropped and the state stays FETCH.
  - Redirect while in DISCARD: pc takes the newer redirect_pc and the state stays DISCARD.
- iq_count always equals the number of entries iq_valid will present; iq_valid = (iq_count != 0).

Decomposition:
- Shared package lc3b_types:
  - Use lc3b_word for instr, pc and address.
  - Add fetch_state_t {FETCH, DISCARD}.
  - Add typedef fetch_entry_t struct {lc3b_word pc; lc3b_word instr;}.
- One sub-module: fetch_fifo.
  - Parameterized DEPTH, storing fetch_entry_t.
  - Ports: push, pop, flush, full, empty, count.
  - fetch_queue keeps the PC, FSM and cache handshake.

Test Plan:
- Reset then single-cycle cache hits returning 16'h1000, 16'h2001, 16'h3002 -> addresses 0x0000, 0x0002, 0x0004 in order; iq_instr/iq_pc read 1000/0000, 2001/0002, 3002/0004 as iq_deq pops.
- Hold iq_deq = 0 with DEPTH = 8 -> iq_count reaches 8 and icache_read stays 0; one iq_deq pulse -> exactly one new request at 0x0010.
- Redirect to 16'h4001 while a request to 0x0006 waits 3 cycles -> FIFO empties the same edge; the 0x0006 response is not pushed; the next request is at 0x4000.
- Redirect coincident with icache_resp and iq_deq -> iq_count = 0 the next cycle; the response data never appears on iq_instr.
- pc = 16'hFFFE hit -> the next request is at 16'h0000.
- Assert rst_n low mid-request with 3 entries queued -> icache_read and iq_valid fall immediately; after release the first request is at RESET_PC.
